mem_port_ctrl: RTL and testbench

- Initiator-side controller for the single-ported unified instruction/data memory.
- Multiplexes instruction-fetch and load/store requests from the core onto one memory port with MemRead/MemWrite/funct3/addr/data_in/data_out semantics.
- Returns registered read data with a one-cycle acknowledge pulse.
- Sits between the pipeline (IF stage and MEM stage) and the memory; the core stalls on missing ack.

---
 rtl/mem_ctrl_pkg.sv | 31 +++
 rtl/mem_align_chk.sv | 27 ++
 rtl/mem_port_ctrl.sv | 151 +++++++++++++++
 tb/tb_mem_port_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the unified-memory port controller.
package mem_ctrl_pkg;

    // Controller service state. last_served reuses DATA/FETCH.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2
    } state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Bytes touched by an access. Unsupported encodings count as one byte,
    // so they never trip the bounds check.
    function automatic logic [2:0] access_size(input logic [2:0] funct3);
        case (funct3)
            F3_LB, F3_LBU: access_size = 3'd1;
            F3_LH, F3_LHU: access_size = 3'd2;
            F3_LW:         access_size = 3'd4;
            default:       access_size = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/mem_align_chk.sv
// Combinational alignment / bounds check for one memory access.
// Only instantiated when MEM_ALIGN_CHECK_EN is defined.
module mem_align_chk
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [2:0]        funct3_i,
    output logic              fault_o
);

    logic [2:0]      size;
    logic [ADDR_W:0] last_byte;
    logic            misalign;

    // Fault when a half/word is misaligned or the access runs past the top address
    always_comb begin
        size      = access_size(funct3_i);
        last_byte = {1'b0, addr_i} + {{(ADDR_W-2){1'b0}}, size} - {{ADDR_W{1'b0}}, 1'b1};
        misalign  = 1'b0;
        if ((funct3_i == F3_LH) || (funct3_i == F3_LHU)) misalign = addr_i[0];
        if (funct3_i == F3_LW)                           misalign = (addr_i[1:0] != 2'b00);
        fault_o   = misalign | last_byte[ADDR_W];
    end

endmodule

// File: rtl/mem_port_ctrl.sv
// Single-port memory controller: arbitrates IF fetches and MEM-stage
// loads/stores onto one memory port, one access per cycle, registered
// read data with a one-cycle ack. Define MEM_ALIGN_CHECK_EN to reject
// misaligned / out-of-range accesses with a fault ack.
module mem_port_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_fault,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [2:0]        dm_funct3,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_fault,
    output logic              mem_read,
    output logic              mem_write,
    output logic [2:0]        mem_funct3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q, state_d;
    state_e            last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        f3_q, f3_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              flt_q, flt_d;

    logic              if_ack_q, dm_ack_q;
    logic              if_flt_q, dm_flt_q;
    logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;

    // A requester in service or in its ack cycle is still holding req; ignore it.
    logic if_pend, dm_pend;
    assign if_pend = if_req & ~if_ack_q & (state_q != FETCH);
    assign dm_pend = dm_req & ~dm_ack_q & (state_q != DATA);

    // Grant: alternate on contention, otherwise serve whoever is pending
    always_comb begin
        state_d = IDLE;
        last_d  = last_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        if (dm_pend && (!if_pend || last_q == FETCH)) begin
            state_d = DATA;
            last_d  = DATA;
            addr_d  = dm_addr;
            f3_d    = dm_funct3;
            we_d    = dm_we;
            wdata_d = dm_wdata;
        end else if (if_pend) begin
            state_d = FETCH;
            last_d  = FETCH;
            addr_d  = if_addr;
            f3_d    = F3_LW;
            we_d    = 1'b0;
            wdata_d = '0;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic chk_fault;
    mem_align_chk #(.ADDR_W(ADDR_W)) u_align_chk (
        .addr_i   (addr_d),
        .funct3_i (f3_d),
        .fault_o  (chk_fault)
    );
    assign flt_d = (state_d != IDLE) & chk_fault;
`else
    assign flt_d = 1'b0;
`endif

    // State and latched request registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= FETCH;
            addr_q  <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            flt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            flt_q   <= flt_d;
        end
    end

    // Capture read data at the end of a service cycle and pulse the ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_ack_q   <= 1'b0;
            dm_ack_q   <= 1'b0;
            if_flt_q   <= 1'b0;
            dm_flt_q   <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            if_ack_q <= (state_q == FETCH);
            dm_ack_q <= (state_q == DATA);
            if_flt_q <= (state_q == FETCH) & flt_q;
            dm_flt_q <= (state_q == DATA) & flt_q;
            if (state_q == FETCH) if_rdata_q <= flt_q ? '0 : mem_rdata;
            if (state_q == DATA)  dm_rdata_q <= (flt_q | we_q) ? '0 : mem_rdata;
        end
    end

    // Memory port driven only from state and latched request; quiet when idle or faulted
    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_funct3 = '0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (state_q != IDLE) begin
            mem_read   = ~we_q & ~flt_q;
            mem_write  = we_q & ~flt_q;
            mem_funct3 = f3_q;
            mem_addr   = addr_q;
            mem_wdata  = wdata_q;
        end
    end

    assign if_ack   = if_ack_q;
    assign if_rdata = if_rdata_q;
    assign if_fault = if_flt_q;
    assign dm_ack   = dm_ack_q;
    assign dm_rdata = dm_rdata_q;
    assign dm_fault = dm_flt_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Self-checking bench for mem_port_ctrl: directed sequences, a vector table
// of single data accesses, and a randomized two-requester run checked
// against a byte-array reference memory.
module tb_mem_port_ctrl;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic              clk, rst_n;
    logic              if_req, if_ack, if_fault;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req, dm_we, dm_ack, dm_fault;
    logic [2:0]        dm_funct3;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata, dm_rdata;
    logic              mem_read, mem_write;
    logic [2:0]        mem_funct3;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    mem_port_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_fault(if_fault),
        .dm_req(dm_req), .dm_we(dm_we), .dm_funct3(dm_funct3), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_fault(dm_fault),
        .mem_read(mem_read), .mem_write(mem_write), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: little-endian bytes, combinational read, write at clock edge, wraps mod 256
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic       mem_init;
    logic [7:0] b0, b1, b2, b3;

    always_comb begin
        b0 = mem[mem_addr];
        b1 = mem[mem_addr + 8'd1];
        b2 = mem[mem_addr + 8'd2];
        b3 = mem[mem_addr + 8'd3];
        mem_rdata = '0;
        if (mem_read) begin
            case (mem_funct3)
                3'b000:  mem_rdata = {{24{b0[7]}}, b0};
                3'b001:  mem_rdata = {{16{b1[7]}}, b1, b0};
                3'b010:  mem_rdata = {b3, b2, b1, b0};
                3'b100:  mem_rdata = {24'd0, b0};
                3'b101:  mem_rdata = {16'd0, b1, b0};
                default: mem_rdata = '0;
            endcase
        end
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
            mem[0] <= 8'hB7; mem[1] <= 8'h20; mem[2] <= 8'h00; mem[3] <= 8'h00;
        end else if (mem_write) begin
            case (mem_funct3)
                3'b000: mem[mem_addr] <= mem_wdata[7:0];
                3'b001: begin
                    mem[mem_addr]        <= mem_wdata[7:0];
                    mem[mem_addr + 8'd1] <= mem_wdata[15:8];
                end
                3'b010: begin
                    mem[mem_addr]        <= mem_wdata[7:0];
                    mem[mem_addr + 8'd1] <= mem_wdata[15:8];
                    mem[mem_addr + 8'd2] <= mem_wdata[23:16];
                    mem[mem_addr + 8'd3] <= mem_wdata[31:24];
                end
                default: ;
            endcase
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: access size and fault from the address rules
    function automatic int ref_size(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        if (f3 == 3'b010) return 4;
        return 1;
    endfunction

    function automatic logic ref_fault(input logic [2:0] f3, input int a);
        int sz;
        sz = ref_size(f3);
        return ALIGN && (((a % sz) != 0) || (a + sz - 1 > 255));
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int a);
        logic [31:0] w;
        w = {ref_mem[(a + 3) % 256], ref_mem[(a + 2) % 256], ref_mem[(a + 1) % 256], ref_mem[a % 256]};
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b010:  return w;
            3'b100:  return {24'd0, w[7:0]};
            3'b101:  return {16'd0, w[15:0]};
            default: return 32'd0;
        endcase
    endfunction

    // One data access from an otherwise idle port
    task automatic dm_op(input logic we, input logic [2:0] f3, input logic [7:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic flt, output logic acc, output int lat);
        logic got;
        dm_req = 1'b1; dm_we = we; dm_funct3 = f3; dm_addr = a; dm_wdata = wd;
        rd = '0; flt = 1'b0; acc = 1'b0; lat = 0; got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            tick();
            lat++;
            if (mem_read || mem_write) acc = 1'b1;
            if (dm_ack) begin
                rd = dm_rdata; flt = dm_fault; got = 1'b1;
            end
        end
        dm_req = 1'b0;
        tick();
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_flt;
    } vec_t;

    vec_t tbl[17];

    initial begin
        logic [31:0] rd;
        logic        flt, acc, seen;
        int          lat, n;
        int          seq[8];
        logic        dm_busy, if_busy;
        int          dm_wait, if_wait;
        logic        r_we;
        logic [2:0]  r_f3;
        int          r_addr, f_addr;
        logic [31:0] r_wd, erd;
        logic        eflt;
        logic [2:0]  f3_pick[6];

        tbl[0]  = '{1'b1, 3'b010, 8'h10, 32'hDEADBEEF, 32'h0, 1'b0};
        tbl[1]  = '{1'b0, 3'b000, 8'h13, 32'h0, 32'hFFFFFFDE, 1'b0};
        tbl[2]  = '{1'b0, 3'b100, 8'h13, 32'h0, 32'h000000DE, 1'b0};
        tbl[3]  = '{1'b0, 3'b001, 8'h12, 32'h0, 32'hFFFFDEAD, 1'b0};
        tbl[4]  = '{1'b0, 3'b101, 8'h12, 32'h0, 32'h0000DEAD, 1'b0};
        tbl[5]  = '{1'b1, 3'b000, 8'h11, 32'h12345655, 32'h0, 1'b0};
        tbl[6]  = '{1'b0, 3'b010, 8'h10, 32'h0, 32'hDEAD55EF, 1'b0};
        tbl[7]  = '{1'b1, 3'b001, 8'h14, 32'hAAAA8001, 32'h0, 1'b0};
        tbl[8]  = '{1'b0, 3'b001, 8'h14, 32'h0, 32'hFFFF8001, 1'b0};
        tbl[9]  = '{1'b0, 3'b010, 8'h41, 32'h0, ALIGN ? 32'h0 : 32'h44434241, ALIGN};
        tbl[10] = '{1'b0, 3'b011, 8'h20, 32'h0, 32'h0, 1'b0};
        tbl[11] = '{1'b1, 3'b111, 8'h20, 32'h99999999, 32'h0, 1'b0};
        tbl[12] = '{1'b0, 3'b010, 8'h20, 32'h0, 32'h23222120, 1'b0};
        tbl[13] = '{1'b1, 3'b010, 8'hFE, 32'h11223344, 32'h0, ALIGN};
        tbl[14] = '{1'b0, 3'b100, 8'hFF, 32'h0, ALIGN ? 32'h000000FF : 32'h00000033, 1'b0};
        tbl[15] = '{1'b0, 3'b100, 8'h00, 32'h0, ALIGN ? 32'h000000B7 : 32'h00000022, 1'b0};
        tbl[16] = '{1'b0, 3'b001, 8'h31, 32'h0, ALIGN ? 32'h0 : 32'h00003231, ALIGN};
        f3_pick = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};

        // Reset held over several edges with requests asserted
        rst_n = 1'b1; mem_init = 1'b1;
        if_req = 1'b1; if_addr = 8'h04;
        dm_req = 1'b1; dm_we = 1'b1; dm_funct3 = 3'b010; dm_addr = 8'h10; dm_wdata = 32'h12345678;
        #2 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            mem_init = 1'b0;
            check("reset_outputs", {if_ack, if_rdata, if_fault, dm_ack, dm_rdata, dm_fault,
                                    mem_read, mem_write, mem_funct3, mem_addr, mem_wdata}, 128'd0);
        end
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        rst_n = 1'b1;
        tick();

        // Fetch only: ack two edges after request
        if_req = 1'b1; if_addr = 8'h00;
        tick();
        check("fetch_service", {mem_read, mem_write, mem_funct3, if_ack}, {1'b1, 1'b0, 3'b010, 1'b0});
        tick();
        check("fetch_ack", {if_ack, if_fault}, {1'b1, 1'b0});
        check("fetch_rdata", if_rdata, 32'h000020B7);
        if_req = 1'b0;
        tick();
        check("fetch_ack_pulse", if_ack, 1'b0);
        check("fetch_rdata_held", if_rdata, 32'h000020B7);

        // Contention from IDLE after reset: DATA first, FETCH back-to-back
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        dm_req = 1'b1; dm_we = 1'b0; dm_funct3 = 3'b010; dm_addr = 8'h40;
        if_req = 1'b1; if_addr = 8'h04;
        tick();
        check("cont_data_first", {mem_read, mem_addr}, {1'b1, 8'h40});
        tick();
        check("cont_dm_ack", {dm_ack, if_ack, mem_read, mem_addr}, {1'b1, 1'b0, 1'b1, 8'h04});
        check("cont_dm_rdata", dm_rdata, 32'h43424140);
        dm_req = 1'b0;
        tick();
        check("cont_if_ack", {if_ack, dm_ack}, {1'b1, 1'b0});
        check("cont_if_rdata", if_rdata, 32'h07060504);
        if_req = 1'b0;
        tick();

        // Alternation with both requesters held continuously
        dm_req = 1'b1; dm_we = 1'b0; dm_funct3 = 3'b010; dm_addr = 8'h40;
        if_req = 1'b1; if_addr = 8'h08;
        n = 0;
        for (int c = 0; c < 60 && n < 8; c++) begin
            tick();
            if (dm_ack || if_ack) check("alt_single_ack", dm_ack & if_ack, 1'b0);
            if (dm_ack && n < 8) begin seq[n] = 0; n++; end
            if (if_ack && n < 8) begin seq[n] = 1; n++; end
        end
        dm_req = 1'b0; if_req = 1'b0;
        check("alt_count", n, 8);
        check("alt_first_data", seq[0], 0);
        for (int i = 1; i < n; i++) check("alt_order", seq[i] != seq[i-1], 1'b1);
        tick(); tick();

        // Vector table of single data accesses
        for (int i = 0; i < 17; i++) begin
            dm_op(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, rd, flt, acc, lat);
            check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
            check($sformatf("tbl%0d_fault", i), flt, tbl[i].exp_flt);
            check($sformatf("tbl%0d_mem_access", i), acc, !tbl[i].exp_flt);
            check($sformatf("tbl%0d_latency", i), lat, 2);
        end

        // Reset in the middle of a store service cycle
        dm_req = 1'b1; dm_we = 1'b1; dm_funct3 = 3'b010; dm_addr = 8'h60; dm_wdata = 32'hCAFEF00D;
        tick();
        check("rst_mid_write_on", mem_write, 1'b1);
        #1 rst_n = 1'b0;
        #1 check("rst_mid_write_off", mem_write, 1'b0);
        dm_req = 1'b0; dm_we = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        check("rst_mid_mem_unchanged", {mem[8'h63], mem[8'h62], mem[8'h61], mem[8'h60]}, 32'h63626160);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin tick(); seen = seen | dm_ack | if_ack; end
        check("rst_mid_no_ack", seen, 1'b0);

        // Randomized two-requester traffic against the reference memory
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        dm_busy = 1'b0; if_busy = 1'b0; dm_wait = 0; if_wait = 0;
        r_we = 1'b0; r_f3 = 3'b000; r_addr = 0; r_wd = '0; f_addr = 0;
        for (int c = 0; c < 600; c++) begin
            tick();
            if (dm_ack) begin
                if (!dm_busy) begin
                    checks++; errors++;
                    $display("FAIL rnd_dm_spurious: got ack=1 expected ack=0");
                end else begin
                    eflt = ref_fault(r_f3, r_addr);
                    erd  = (eflt || r_we) ? 32'd0 : ref_load(r_f3, r_addr);
                    check("rnd_dm", {dm_fault, dm_rdata}, {eflt, erd});
                    if (r_we && !eflt) begin
                        if (r_f3 == 3'b000 || r_f3 == 3'b001 || r_f3 == 3'b010)
                            for (int k = 0; k < ref_size(r_f3); k++)
                                ref_mem[(r_addr + k) % 256] = r_wd[8*k +: 8];
                    end
                    dm_busy = 1'b0;
                end
            end else if (dm_busy) begin
                dm_wait++;
                if (dm_wait > 4) begin
                    checks++; errors++;
                    $display("FAIL rnd_dm_timeout: got no ack after %0d cycles expected ack within 4", dm_wait);
                    dm_busy = 1'b0;
                end
            end
            if (if_ack) begin
                if (!if_busy) begin
                    checks++; errors++;
                    $display("FAIL rnd_if_spurious: got ack=1 expected ack=0");
                end else begin
                    eflt = ref_fault(3'b010, f_addr);
                    erd  = eflt ? 32'd0 : ref_load(3'b010, f_addr);
                    check("rnd_if", {if_fault, if_rdata}, {eflt, erd});
                    if_busy = 1'b0;
                end
            end else if (if_busy) begin
                if_wait++;
                if (if_wait > 4) begin
                    checks++; errors++;
                    $display("FAIL rnd_if_timeout: got no ack after %0d cycles expected ack within 4", if_wait);
                    if_busy = 1'b0;
                end
            end
            if (!dm_busy) begin
                if ($urandom_range(9) < 7) begin
                    r_we   = 1'($urandom_range(1));
                    r_f3   = f3_pick[$urandom_range(5)];
                    r_addr = $urandom_range(255);
                    r_wd   = $urandom;
                    dm_req = 1'b1; dm_we = r_we; dm_funct3 = r_f3;
                    dm_addr = 8'(r_addr); dm_wdata = r_wd;
                    dm_busy = 1'b1; dm_wait = 0;
                end else dm_req = 1'b0;
            end
            if (!if_busy) begin
                if ($urandom_range(9) < 7) begin
                    f_addr = $urandom_range(255);
                    if ($urandom_range(1) == 0) f_addr = f_addr & 32'hFC;
                    if_req = 1'b1; if_addr = 8'(f_addr);
                    if_busy = 1'b1; if_wait = 0;
                end else if_req = 1'b0;
            end
        end
        dm_req = 1'b0; if_req = 1'b0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
